// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the multiply/divide unit.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned MD_OP_W  = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd11;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               md_start,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned PW      = 2 * WIDTH;

  md_state_e            state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     pend_hi;
  logic [WIDTH-1:0]     pend_lo;
  logic                 pend_we;

  logic [PW-1:0]        prod_s;
  logic [PW-1:0]        prod_u;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     div_s_b;
  logic [WIDTH-1:0]     div_u_b;
  logic [WIDTH-1:0]     uq_s;
  logic [WIDTH-1:0]     ur_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     quo_u;
  logic [WIDTH-1:0]     rem_u;
  logic                 div_zero;

  // Sign-extending to 2W makes a plain modular multiply yield the signed product.
  assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign prod_u = {WIDTH'(0), src_a} * {WIDTH'(0), src_b};

  // Signed divide via magnitudes; MIN / -1 falls out as MIN rem 0.
  assign a_neg    = src_a[WIDTH-1];
  assign b_neg    = src_b[WIDTH-1];
  assign mag_a    = a_neg ? (~src_a + WIDTH'(1)) : src_a;
  assign mag_b    = b_neg ? (~src_b + WIDTH'(1)) : src_b;
  assign div_zero = (src_b == WIDTH'(0));
  assign div_s_b  = div_zero ? WIDTH'(1) : mag_b;
  assign div_u_b  = div_zero ? WIDTH'(1) : src_b;
  assign uq_s     = mag_a / div_s_b;
  assign ur_s     = mag_a % div_s_b;
  assign quo_s    = (a_neg ^ b_neg) ? (~uq_s + WIDTH'(1)) : uq_s;
  assign rem_s    = a_neg ? (~ur_s + WIDTH'(1)) : ur_s;
  assign quo_u    = src_a / div_u_b;
  assign rem_u    = src_a % div_u_b;

  // Issue, count down, commit; MTHI/MTLO bypass the counter entirely.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md_start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                pend_hi <= (md_op == MD_MULT) ? prod_s[PW-1:WIDTH] : prod_u[PW-1:WIDTH];
                pend_lo <= (md_op == MD_MULT) ? prod_s[WIDTH-1:0]  : prod_u[WIDTH-1:0];
                pend_we <= 1'b1;
                cnt     <= CW'(MUL_CYCLES - 1);
                state   <= ST_MUL;
                busy    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi <= (md_op == MD_DIV) ? rem_s : rem_u;
                pend_lo <= (md_op == MD_DIV) ? quo_s : quo_u;
                pend_we <= !div_zero;
                cnt     <= CW'(DIV_CYCLES - 1);
                state   <= ST_DIV;
                busy    <= 1'b1;
              end
              MD_MTHI: hi <= src_a;
              MD_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CW'(0)) begin
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage combinational ALU with the attached multiply/divide unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  input  logic [ALU_OP_W-1:0]      alu_op,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         result,
  output logic                     overflow,
  output logic                     equal,
  input  logic [MD_OP_W-1:0]       md_op,
  input  logic                     md_start,
  output logic                     busy,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);

  localparam int unsigned HW = WIDTH / 2;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_s;
  logic             lt_u;

  assign sum   = src_a + src_b;
  assign diff  = src_a - src_b;
  assign lt_s  = $signed(src_a) < $signed(src_b);
  assign lt_u  = src_a < src_b;
  assign equal = (src_a == src_b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result   = sum;
        overflow = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      ALU_LUI:  result = {src_b[HW-1:0], HW'(0)};
      ALU_SLTU: result = WIDTH'(lt_u);
      ALU_SLT:  result = WIDTH'(lt_s);
      ALU_SLL:  result = src_b << shamt;
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      ALU_XOR:  result = src_a ^ src_b;
      ALU_NOR:  result = ~(src_a | src_b);
      ALU_SRL:  result = src_b >> shamt;
      ALU_SRA:  result = WIDTH'($signed(src_b) >>> shamt);
      default:  result = '0;
    endcase
  end

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_unit (
    .clk      (clk),
    .reset_n  (reset_n),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_op    (md_op),
    .md_start (md_start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage ALU with an attached multi-cycle multiply/divide unit (MDU) and architectural HI/LO registers. It sits in the EX stage of the pipelined CPU. Single-cycle ALU ops are combinational. MULT/MULTU/DIV/DIVU run for a fixed latency with a `busy` flag that the hazard unit uses to stall HI/LO consumers. MTHI/MTLO write HI/LO directly.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU; ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `src_a`, input, WIDTH: operand A (rs).
- `src_b`, input, WIDTH: operand B (rt or extended immediate).
- `alu_op`, input, 4: ALU operation select.
- `shamt`, input, $clog2(WIDTH): shift amount.
- `result`, output, WIDTH: combinational ALU result.
- `overflow`, output, 1: signed overflow for ADD/SUB; 0 for every other op.
- `equal`, output, 1: `src_a == src_b`.
- `md_op`, input, 3: MDU operation select.
- `md_start`, input, 1: MDU operation issue strobe, sampled at the rising edge.
- `busy`, output, 1: MDU operation in flight.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- `alu_op` encodings:
  - 0 ADD, 1 SUB.
  - 2 LUI: `src_b[WIDTH/2-1:0]` shifted left by WIDTH/2.
  - 3 SLTU (unsigned), 4 SLT (signed).
  - 5 SLL, 6 OR, 7 AND, 8 XOR, 9 NOR.
  - 10 SRL (logical), 11 SRA (arithmetic). All three shifts shift `src_b` by `shamt`.
  - 12–15: `result` = 0. There is no latch path and every code is defined.
- SLT/SLTU results are zero-extended 1.
- `overflow` for ADD: operands have the same sign and the sum's sign differs. For SUB: operands have different signs and the difference's sign differs from `src_a`. `result` is always the wrapped value.
- `md_op` encodings: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
- Issue rule: an MDU op is accepted only when `md_start`=1, `busy`=0 and `md_op` is not NOP.
  - `md_start` while `busy`=1 is ignored entirely, including MTHI/MTLO. The hazard unit is required to stall such instructions.
- MULT/MULTU: the 2·WIDTH-bit product (signed or unsigned) is captured into pending registers at issue. On completion, `hi` = upper half and `lo` = lower half.
- DIV/DIVU: `lo` = quotient and `hi` = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / −1 gives `lo`=MIN and `hi`=0.
  - Divisor 0: `hi`/`lo` are left unchanged at completion. Busy timing is still the full DIV_CYCLES.
- MTHI/MTLO: `hi`/`lo` ← `src_a` at the issuing edge. `busy` is not raised.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL or DIV on an accepted mult or div op. A down-counter is loaded with MUL_CYCLES−1 or DIV_CYCLES−1.
  - In MUL or DIV: decrement each cycle. When the count is 0, commit pending values to HI/LO and return to IDLE.
- `busy` = (state ≠ IDLE), registered.

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE, counter=0, pending registers=0, `hi`=0, `lo`=0, `busy`=0.
  - Reset mid-operation aborts the operation with no HI/LO commit.
  - Combinational outputs are unaffected by reset.
- ALU path: zero latency, purely combinational from inputs.
- MULT/DIV issued at edge E0 with N = MUL_CYCLES or DIV_CYCLES:
  - `busy`=1 from just after E0 until edge EN.
  - `hi`/`lo` take their new values at EN, and `busy` falls at EN.
  - A new op may be issued at the edge EN+1 at the earliest. An op at EN itself is seen with `busy`=1 and is ignored.
- N=1: `busy` is high for exactly one cycle.
- MTHI/MTLO issued at E0: new value visible just after E0. Zero busy cycles; back-to-back issue is allowed every cycle.
- Operands are captured at issue. Changes to `src_a`/`src_b` during busy have no effect on the result.

## Structure
- Package `alu_pkg`:
  - `alu_op` localparams (ALU_ADD … ALU_SRA) and `md_op` localparams (MD_NOP … MD_MTLO).
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DIV).
- Sub-module `md_unit`: FSM, counter, pending and HI/LO registers, and signed/unsigned mult/div arithmetic.
- Top level `alu_mdu`: the combinational ALU plus the `md_unit` instance.

## Test plan
- ADD 0x7FFFFFFF + 1 → `result`=0x80000000, `overflow`=1. SUB 0x80000000 − 1 → `result`=0x7FFFFFFF, `overflow`=1. SRA 0x80000000 by 4 → 0xF8000000. LUI with `src_b`=0x1234 → 0x12340000. Op 13 → 0.
- MULT −3 × 5 → `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU 0xFFFFFFFF × 2 → `hi`=1, `lo`=0xFFFFFFFE.
- DIV −7 / 2 → after 10 busy cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7 / 0 → `hi`/`lo` unchanged, `busy` still 10 cycles. DIV 0x80000000 / −1 → `lo`=0x80000000, `hi`=0.
- While busy from MULT: issue MTHI with 0xAA → ignored. Change `src_a` mid-op → product unchanged. Issue at edge EN → ignored. Issue at EN+1 → accepted.
- MTLO 0x55 then MTHI 0x66 on consecutive edges → `lo`=0x55 and `hi`=0x66 next cycle; `busy` never asserted.
- Assert `reset_n`=0 at cycle 3 of a DIV → `busy`=0 and `hi`=`lo`=0 next cycle; no later commit.
